// File: rtl/inject_ctrl_pkg.sv
// Shared widths, injector FSM encoding and flit helpers for the local injection path.
package inject_ctrl_pkg;

    localparam int WIDTH_PORT = 32;
    localparam int NUM_PORT   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } injState_t;

    // An all-zero word means "no flit" on router inputs.
    function automatic logic isFlit(input logic [WIDTH_PORT-1:0] flit);
        return |flit;
    endfunction

endpackage

// File: rtl/inject_ctrl_if.sv
// PE-side handshake plus router-side injection signals of the local port.
interface inject_ctrl_if;
    import inject_ctrl_pkg::*;

    logic [WIDTH_PORT-1:0] pe_flit;
    logic                  pe_valid;
    logic                  pe_ready;
    logic [NUM_PORT-2:0]   link_busy;
    logic [WIDTH_PORT-1:0] dinLocal;
    logic                  starve;
    logic [15:0]           inj_cnt;

    modport master (
        output pe_flit, pe_valid, link_busy,
        input  pe_ready, dinLocal, starve, inj_cnt
    );

    modport slave (
        input  pe_flit, pe_valid, link_busy,
        output pe_ready, dinLocal, starve, inj_cnt
    );

endinterface

// File: rtl/inject_ctrl_injQueue.sv
// Circular flit queue, DEPTH x WIDTH; head is a registered read, no bypass.
// Push while full and pop while empty are ignored.
module injQueue #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushDat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [LW-1:0]    cnt;
    logic             doPush;
    logic             doPop;

    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            cnt <= cnt + LW'(doPush) - LW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushDat;
    end

    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rdPtr];
    assign level = cnt;

endmodule

// File: rtl/inject_ctrl.sv
// Local-port injector: queues PE flits and issues them only when the router will not drop them.
// A flit is withheld whenever all four links were busy last cycle; long stalls raise starve.
module inject_ctrl
    import inject_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 16
) (
    input  logic          clk,
    input  logic          reset,
    inject_ctrl_if.slave  bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_TH + 1);

    logic [NUM_PORT-2:0]   busyQ;
    injState_t             state;
    logic [SW-1:0]         stallCnt;
    logic                  starveQ;
    logic [15:0]           injCnt;

    logic                  full;
    logic                  empty;
    logic [WIDTH_PORT-1:0] head;
    logic [LW-1:0]         level;
    logic [LW-1:0]         nextLevel;
    logic                  injectOk;
    logic                  push;
    logic                  pop;

    // busyQ mirrors router stage-1 occupancy in the cycle our flit would land.
    assign injectOk  = ~&busyQ;
    assign pop       = ~empty & injectOk;
    assign push      = bus.pe_valid & ~full & isFlit(bus.pe_flit);
    assign nextLevel = level + LW'(push) - LW'(pop);

    injQueue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH_PORT)
    ) u_injQueue (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pushDat (bus.pe_flit),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head),
        .level   (level)
    );

    // State tracks the conditions the queue and busyQ will present next cycle,
    // so STALL never coincides with a pop and SEND always does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busyQ    <= '0;
            state    <= IDLE;
            stallCnt <= '0;
            starveQ  <= 1'b0;
            injCnt   <= '0;
        end else begin
            busyQ <= bus.link_busy;

            if (nextLevel == '0)    state <= IDLE;
            else if (~&bus.link_busy) state <= SEND;
            else                    state <= STALL;

            if (state == STALL) begin
                if (stallCnt != SW'(STARVE_TH)) stallCnt <= stallCnt + SW'(1);
            end else begin
                stallCnt <= '0;
            end

            if (pop)                              starveQ <= 1'b0;
            else if (stallCnt == SW'(STARVE_TH))  starveQ <= 1'b1;

            if (pop) injCnt <= injCnt + 16'd1;
        end
    end

    assign bus.dinLocal = pop ? head : '0;
    assign bus.pe_ready = ~full;
    assign bus.starve   = starveQ;
    assign bus.inj_cnt  = injCnt;

endmodule

// File: tb/tb_inject_ctrl.sv
// Randomized and directed checks of inject_ctrl against a queue-based reference model.
module tb_inject_ctrl;

    localparam int DEPTH = 4;
    localparam int TH    = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    inject_ctrl_if bus ();

    inject_ctrl #(.DEPTH(DEPTH), .STARVE_TH(TH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mq[$];
    logic [3:0]  mBusyPrev;
    int          mBlocked;
    bit          mStarve;
    logic [15:0] mInj;
    bit          lastAcc;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, compare, then advance the model over one clock.
    task automatic cycle(input logic [31:0] flit, input logic valid, input logic [3:0] busy);
        logic [31:0] expDin;
        bit pop, push, stalled;
        bus.pe_flit   = flit;
        bus.pe_valid  = valid;
        bus.link_busy = busy;
        pop    = (mq.size() > 0) && (mBusyPrev != 4'hF);
        expDin = pop ? mq[0] : 32'h0;
        checkVal("dinLocal", bus.dinLocal, expDin);
        checkVal("pe_ready", 32'(bus.pe_ready), 32'(mq.size() < DEPTH));
        checkVal("starve", 32'(bus.starve), 32'(mStarve));
        checkVal("inj_cnt", 32'(bus.inj_cnt), 32'(mInj));
        lastAcc = valid && (mq.size() < DEPTH);
        push    = lastAcc && (flit != 32'h0);
        @(posedge clk);
        stalled = (mq.size() > 0) && !pop;
        if (pop) mStarve = 1'b0;
        else if (mBlocked == TH) mStarve = 1'b1;
        if (stalled) begin
            if (mBlocked < TH) mBlocked++;
        end else begin
            mBlocked = 0;
        end
        if (pop) begin
            void'(mq.pop_front());
            mInj++;
        end
        if (push) mq.push_back(flit);
        mBusyPrev = busy;
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b0;
        #1;
        checkVal("rst_dinLocal", bus.dinLocal, 32'h0);
        checkVal("rst_pe_ready", 32'(bus.pe_ready), 32'h1);
        checkVal("rst_starve", 32'(bus.starve), 32'h0);
        checkVal("rst_inj_cnt", 32'(bus.inj_cnt), 32'h0);
        mq.delete();
        mBusyPrev = 4'h0;
        mBlocked  = 0;
        mStarve   = 1'b0;
        mInj      = 16'h0;
        bus.pe_flit   = 32'h0;
        bus.pe_valid  = 1'b0;
        bus.link_busy = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] f [5];
        logic [31:0] seq [6];
        logic [31:0] rf;
        logic [3:0]  rb;
        bit hold;
        int runLen;
        bit busyMode;

        bus.pe_flit   = 32'h0;
        bus.pe_valid  = 1'b0;
        bus.link_busy = 4'h0;
        @(negedge clk);
        applyReset();

        // Single flit, free links: issued next cycle, counter follows the pop
        cycle(32'h5A5A_00A5, 1'b1, 4'h0);
        checkVal("r030_din", bus.dinLocal, 32'h5A5A_00A5);
        cycle(32'h0, 1'b0, 4'h0);
        checkVal("r030_din_after", bus.dinLocal, 32'h0);
        checkVal("r030_inj", 32'(bus.inj_cnt), 32'h1);
        repeat (2) cycle(32'h0, 1'b0, 4'h0);

        // One busy cycle delays the queued flit by exactly one cycle
        cycle(32'h0000_0031, 1'b1, 4'hF);
        checkVal("r031_held", bus.dinLocal, 32'h0);
        cycle(32'h0, 1'b0, 4'h0);
        checkVal("r031_issue", bus.dinLocal, 32'h0000_0031);
        repeat (2) cycle(32'h0, 1'b0, 4'h0);

        // Fill under full blockage, then drain in order
        for (int i = 0; i < 5; i++) f[i] = 32'h1000_0000 + 32'(i + 1);
        for (int i = 0; i < 4; i++) cycle(f[i], 1'b1, 4'hF);
        checkVal("r032_full", 32'(bus.pe_ready), 32'h0);
        repeat (2) cycle(f[4], 1'b1, 4'hF);
        cycle(f[4], 1'b1, 4'h0);
        for (int i = 0; i < 5; i++) seq[i] = f[i];
        seq[5] = 32'h0;
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkVal("r032_order", bus.dinLocal, seq[i]);
            cycle(hold ? f[4] : 32'h0, hold, 4'h0);
            if (lastAcc) hold = 1'b0;
        end
        repeat (2) cycle(32'h0, 1'b0, 4'h0);

        // Starvation threshold and release
        cycle(32'hC0DE_0033, 1'b1, 4'hF);
        for (int i = 1; i <= 20; i++) begin
            cycle(32'h0, 1'b0, 4'hF);
            if (i == 16) checkVal("r033_starve16", 32'(bus.starve), 32'h0);
            if (i == 17) checkVal("r033_starve17", 32'(bus.starve), 32'h1);
        end
        cycle(32'h0, 1'b0, 4'h0);
        checkVal("r033_pop", bus.dinLocal, 32'hC0DE_0033);
        checkVal("r033_starve_hold", 32'(bus.starve), 32'h1);
        cycle(32'h0, 1'b0, 4'h0);
        checkVal("r033_starve_clr", 32'(bus.starve), 32'h0);

        // Zero flit completes handshake but is discarded
        checkVal("r034_ready", 32'(bus.pe_ready), 32'h1);
        cycle(32'h0, 1'b1, 4'h0);
        checkVal("r034_din", bus.dinLocal, 32'h0);
        cycle(32'h0, 1'b0, 4'h0);
        checkVal("r034_din2", bus.dinLocal, 32'h0);

        // Reset mid-operation with queued flits and starve raised
        for (int i = 0; i < 3; i++) cycle(32'h3500_0000 + 32'(i + 1), 1'b1, 4'hF);
        repeat (20) cycle(32'h0, 1'b0, 4'hF);
        checkVal("r035_starve_pre", 32'(bus.starve), 32'h1);
        applyReset();
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0, 1'b0, 4'h0);
            checkVal("r035_no_stale", bus.dinLocal, 32'h0);
        end

        // Randomized traffic with bursty link blockage
        runLen   = 0;
        busyMode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (runLen == 0) begin
                runLen   = $urandom_range(1, 24);
                busyMode = ($urandom_range(0, 1) == 1);
            end
            runLen--;
            rb = busyMode ? 4'hF : 4'($urandom_range(0, 15));
            rf = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            cycle(rf, ($urandom_range(0, 9) < 7), rb);
            if (c == 1500) applyReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
